// File: rtl/tcm_lsu.sv
// Load/store unit between a CPU request port and a single-cycle-read 32-bit TCM.
// Latency: store/error response 1 cycle after accept, load response 2 cycles after accept.
// Backpressure: one access in flight; req_ready_o drops until the response is consumed.
module tcm_lsu #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic [3:0]        mem_wr_o,
    input  logic [31:0]       mem_data_i
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                req_err;
    logic [3:0]          byte_en;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         ld_ext;

    assign req_ready_o  = (state_q == IDLE);
    assign accept       = req_ready_o && req_valid_i;
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign mem_addr_o   = req_ready_o ? req_addr_i[ADDR_W+1:2] : maddr_q;

    // Shift rather than slice so the range check stays legal for any ADDR_W.
    assign req_err = (req_size_i == 2'd3)
                  || (req_size_i == 2'd1 && req_addr_i[0])
                  || (req_size_i == 2'd2 && req_addr_i[1:0] != 2'd0)
                  || ((req_addr_i >> (ADDR_W + 2)) != 32'd0);

    always_comb begin
        byte_en    = 4'b0000;
        mem_data_o = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                byte_en    = 4'b0001 << req_addr_i[1:0];
                mem_data_o = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                byte_en    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_data_o = {2{req_wdata_i[15:0]}};
            end
            2'd2:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // rst_i gates the strobe directly so no write can slip out during reset.
    assign mem_wr_o = (accept && req_we_i && !req_err && rst_i) ? byte_en : 4'b0000;

    always_comb begin
        ld_byte = mem_data_i[7:0];
        case (lane_q)
            2'd1:    ld_byte = mem_data_i[15:8];
            2'd2:    ld_byte = mem_data_i[23:16];
            2'd3:    ld_byte = mem_data_i[31:24];
            default: ld_byte = mem_data_i[7:0];
        endcase
        ld_half = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
        case (size_q)
            2'd0:    ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'd1:    ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = mem_data_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    maddr_d = req_addr_i[ADDR_W+1:2];
                    lane_d  = req_addr_i[1:0];
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    err_d   = req_err;
                    rdata_d = 32'd0;
                    state_d = (req_we_i || req_err) ? RESP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                rdata_d = ld_ext;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            maddr_q <= '0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_tcm_lsu.sv
// Directed bench for tcm_lsu with a behavioural single-cycle-read RAM.
module tb_tcm_lsu;

    localparam int ADDR_W = 14;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [3:0]        mem_wr_o;
    logic [31:0]       mem_data_i;

    int errs   = 0;
    int checks = 0;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    tcm_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_wr_o(mem_wr_o), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        for (int i = 0; i < 4; i++)
            if (mem_wr_o[i]) ram[mem_addr_o][8*i +: 8] <= mem_data_o[8*i +: 8];
        mem_data_i <= ram[mem_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge: present a request and let it settle.
    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        #1;
    endtask

    // Clock the accept edge, then drop the request at the next negedge.
    task automatic accept_edge();
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_addr_i  = 32'd0;
        req_wdata_i = 32'd0;
        #1;
    endtask

    task automatic next_neg();
        @(negedge clk_i);
        #1;
    endtask

    task automatic consume();
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        #1;
        chk("consume_valid", {31'd0, resp_valid_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b0;
        resp_ready_i = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
        chk("rst_wr", {28'd0, mem_wr_o}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rst_rdata", resp_rdata_o, 32'd0);
        chk("rst_err", {31'd0, resp_err_o}, 32'd0);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;

        // SW 0x10
        drive(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("sw_ready", {31'd0, req_ready_o}, 32'd1);
        chk("sw_wr", {28'd0, mem_wr_o}, 32'hF);
        chk("sw_addr", {18'd0, mem_addr_o}, 32'd4);
        chk("sw_data", mem_data_o, 32'hDEAD_BEEF);
        accept_edge();
        chk("sw_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("sw_err", {31'd0, resp_err_o}, 32'd0);
        chk("sw_rdata", resp_rdata_o, 32'd0);
        chk("sw_busy", {31'd0, req_ready_o}, 32'd0);
        consume();

        // SB 0x13 <- 0x80
        drive(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_0080);
        chk("sb_wr", {28'd0, mem_wr_o}, 32'h8);
        chk("sb_data", mem_data_o, 32'h8080_8080);
        chk("sb_addr", {18'd0, mem_addr_o}, 32'd4);
        accept_edge();
        chk("sb_valid", {31'd0, resp_valid_o}, 32'd1);
        consume();

        // LB 0x13
        drive(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'd0);
        chk("lb_wr", {28'd0, mem_wr_o}, 32'd0);
        accept_edge();
        chk("lb_wait_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("lb_addr_hold", {18'd0, mem_addr_o}, 32'd4);
        next_neg();
        chk("lb_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("lb_rdata", resp_rdata_o, 32'hFFFF_FF80);
        consume();

        // LBU 0x13
        drive(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'd0);
        accept_edge();
        chk("lbu_wait_valid", {31'd0, resp_valid_o}, 32'd0);
        next_neg();
        chk("lbu_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("lbu_rdata", resp_rdata_o, 32'h0000_0080);
        consume();

        // LW 0x10 sees the merged word
        drive(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0);
        accept_edge();
        next_neg();
        chk("lw_rdata", resp_rdata_o, 32'h80AD_BEEF);
        chk("lw_err", {31'd0, resp_err_o}, 32'd0);
        consume();

        // Misaligned LW 0x2
        drive(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'd0);
        chk("mis_wr", {28'd0, mem_wr_o}, 32'd0);
        accept_edge();
        chk("mis_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("mis_err", {31'd0, resp_err_o}, 32'd1);
        chk("mis_rdata", resp_rdata_o, 32'd0);
        consume();

        // Out-of-range SW 0x10000
        drive(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF);
        chk("oor_wr", {28'd0, mem_wr_o}, 32'd0);
        accept_edge();
        chk("oor_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("oor_err", {31'd0, resp_err_o}, 32'd1);
        consume();

        // Reserved size store
        drive(1'b1, 2'd3, 1'b0, 32'h0000_0020, 32'h1111_1111);
        chk("rsv_wr", {28'd0, mem_wr_o}, 32'd0);
        accept_edge();
        chk("rsv_err", {31'd0, resp_err_o}, 32'd1);
        consume();

        // SH 0x22 <- 0x8001, then LH 0x22 under backpressure
        drive(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_8001);
        chk("sh_wr", {28'd0, mem_wr_o}, 32'hC);
        chk("sh_data", mem_data_o, 32'h8001_8001);
        accept_edge();
        consume();
        drive(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'd0);
        accept_edge();
        next_neg();
        chk("lh_rdata", resp_rdata_o, 32'hFFFF_8001);
        drive(1'b1, 2'd2, 1'b0, 32'h0000_0030, 32'hCAFE_F00D);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'd0, resp_valid_o}, 32'd1);
            chk("bp_rdata", resp_rdata_o, 32'hFFFF_8001);
            chk("bp_ready", {31'd0, req_ready_o}, 32'd0);
            chk("bp_wr", {28'd0, mem_wr_o}, 32'd0);
            next_neg();
        end
        req_valid_i = 1'b0;
        consume();

        // Reset while in RD_WAIT
        drive(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0);
        accept_edge();
        chk("rdw_pre_valid", {31'd0, resp_valid_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("rdw_rst_valid", {31'd0, resp_valid_o}, 32'd0);
        next_neg();
        chk("rdw_rst_hold", {31'd0, resp_valid_o}, 32'd0);
        rst_i = 1'b1;
        next_neg();
        chk("rdw_rel_valid", {31'd0, resp_valid_o}, 32'd0);
        chk("rdw_rel_ready", {31'd0, req_ready_o}, 32'd1);
        drive(1'b0, 2'd0, 1'b1, 32'h0000_0010, 32'd0);
        accept_edge();
        next_neg();
        chk("post_valid", {31'd0, resp_valid_o}, 32'd1);
        chk("post_rdata", resp_rdata_o, 32'h0000_00EF);
        consume();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
